// File: rtl/vec_packer_if.sv
// Handshake and bus bundle between an element producer, the vec_packer and the frame consumer.
interface vec_packer_if #(
    parameter int EBW = 32,
    parameter int LEN = 128,
    parameter int CW  = $clog2(LEN + 1)
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [EBW:0]      in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [(EBW+1)*LEN-1:0]   flat_out;
    logic [CW-1:0]            count;
    logic                     err_len;
    logic [15:0]              frame_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, flat_out, count, err_len, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, flat_out, count, err_len, frame_cnt
    );
endinterface

// File: rtl/vec_packer.sv
// Packs a stream of signed elements row-major into a flat vector bus and hands it off by valid/ready.
// Optional macro VEC_PACKER_RELU_EN clamps negative elements to zero on write.
module vec_packer #(
    parameter int EBW  = 32,
    parameter int ROWS = 1,
    parameter int COLS = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_packer_if.slave   bus
);
    localparam int LEN = ROWS * COLS;
    localparam int W   = EBW + 1;
    localparam int CW  = $clog2(LEN + 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [W*LEN-1:0]   flat_q, flat_d;
    logic [CW-1:0]      count_q, count_d;
    logic               err_q, err_d;
    logic [15:0]        fcnt_q, fcnt_d;
    logic [W-1:0]       elem_s;
    logic               last_slot_s;

    assign last_slot_s = (count_q == CW'(LEN - 1));

    // Element value as written into the slot (activation applied when enabled).
    always_comb begin
`ifdef VEC_PACKER_RELU_EN
        if (bus.in_data[EBW]) begin
            elem_s = {W{1'b0}};
        end else begin
            elem_s = bus.in_data;
        end
`else
        elem_s = bus.in_data;
`endif
    end

    // Next-state and datapath update for the fill/handoff FSM.
    always_comb begin
        state_d = state_q;
        flat_d  = flat_q;
        count_d = count_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_FILL: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < LEN; k++) begin
                        if (count_q == CW'(k)) begin
                            flat_d[k*W +: W] = elem_s;
                        end else begin
                            flat_d[k*W +: W] = flat_q[k*W +: W];
                        end
                    end
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                    // err_len only changes when a frame closes, so it reports the last completed frame.
                    if (bus.in_last || last_slot_s) begin
                        state_d = S_FULL;
                        err_d   = bus.in_last ^ last_slot_s;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FULL: begin
                if (bus.out_ready) begin
                    state_d = S_FILL;
                    flat_d  = {(W*LEN){1'b0}};
                    count_d = {CW{1'b0}};
                    fcnt_d  = fcnt_q + 16'd1;
                end else begin
                    state_d = S_FULL;
                end
            end
            default: begin
                state_d = S_FILL;
                flat_d  = {(W*LEN){1'b0}};
                count_d = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            flat_q  <= {(W*LEN){1'b0}};
            count_q <= {CW{1'b0}};
            err_q   <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            flat_q  <= flat_d;
            count_q <= count_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.out_valid = (state_q == S_FULL);
    assign bus.flat_out  = flat_q;
    assign bus.count     = count_q;
    assign bus.err_len   = err_q;
    assign bus.frame_cnt = fcnt_q;
endmodule

// File: tb/tb_vec_packer.sv
// Directed self-checking bench for vec_packer with EBW=7, ROWS=1, COLS=4.
module tb_vec_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vec_packer_if #(.EBW(7), .LEN(4)) bus ();

    vec_packer #(.EBW(7), .ROWS(1), .COLS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents one element, returns at the following negedge.
    task automatic send(input logic [7:0] d, input logic l);
        chk("send_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic handoff(input logic [15:0] exp_fcnt);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("ho_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("ho_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("ho_count",     {61'd0, bus.count},     64'd0);
        chk("ho_flat",      {32'd0, bus.flat_out},  64'd0);
        chk("ho_frame_cnt", {48'd0, bus.frame_cnt}, {48'd0, exp_fcnt});
    endtask

    task automatic check_frame(input string tag, input logic [31:0] flat, input logic err, input logic [2:0] cnt);
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({tag, "_in_ready"},  {63'd0, bus.in_ready},  64'd0);
        chk({tag, "_flat"},      {32'd0, bus.flat_out},  {32'd0, flat});
        chk({tag, "_err_len"},   {63'd0, bus.err_len},   {63'd0, err});
        chk({tag, "_count"},     {61'd0, bus.count},     {61'd0, cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_mixed;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_flat",      {32'd0, bus.flat_out},  64'd0);
        chk("rst_count",     {61'd0, bus.count},     64'd0);
        chk("rst_err",       {63'd0, bus.err_len},   64'd0);
        chk("rst_fcnt",      {48'd0, bus.frame_cnt}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame
        send(8'h01, 1'b0);
        chk("t1_count1", {61'd0, bus.count}, 64'd1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        check_frame("t1", 32'h04030201, 1'b0, 3'd4);
        handoff(16'd1);

        // Back-pressure: in_valid held high in FULL must not be accepted
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_frame("t2_hold", 32'h04030201, 1'b0, 3'd4);
        end
        bus.in_valid = 1'b0;
        handoff(16'd2);

        // Early in_last: zero fill and length error
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        check_frame("t3", 32'h00002211, 1'b1, 3'd2);
        handoff(16'd3);
        chk("t3_err_held", {63'd0, bus.err_len}, 64'd1);

        // Missing in_last: frame closes at LEN, next element starts a new frame
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b0);
        send(8'h0D, 1'b0);
        check_frame("t4", 32'h0D0C0B0A, 1'b1, 3'd4);
        handoff(16'd4);
        send(8'h55, 1'b0);
        chk("t4_slot0_flat",  {32'd0, bus.flat_out}, 64'h0000_0055);
        chk("t4_slot0_count", {61'd0, bus.count},    64'd1);
        chk("t4_slot0_ov",    {63'd0, bus.out_valid}, 64'd0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b1);
        check_frame("t4b", 32'h88776655, 1'b0, 3'd4);
        handoff(16'd5);

        // Signed values
`ifdef VEC_PACKER_RELU_EN
        exp_mixed = 32'h007F0000;
`else
        exp_mixed = 32'h007F80FF;
`endif
        send(8'hFF, 1'b0);
        send(8'h80, 1'b0);
        send(8'h7F, 1'b0);
        send(8'h00, 1'b1);
        check_frame("t5", exp_mixed, 1'b0, 3'd4);
        handoff(16'd6);

        // Reset mid-frame discards partial data
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_rst_count",     {61'd0, bus.count},     64'd0);
        chk("t6_rst_flat",      {32'd0, bus.flat_out},  64'd0);
        chk("t6_rst_fcnt",      {48'd0, bus.frame_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h21, 1'b0);
        send(8'h43, 1'b0);
        send(8'h65, 1'b0);
        send(8'h87, 1'b1);
        check_frame("t6", 32'h87654321, 1'b0, 3'd4);
        handoff(16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_packer.md
Name: vec_packer

Overview:
- Sequential writer for the flattened vector buses consumed by the dense layers.
- Accepts one signed element per handshake and places it row-major into a flat bus, using the same slot layout the dense layers unpack.
- Presents the completed vector with a valid/ready handshake. This replaces the one-shot, delay-driven bus loading used today in the classifier chain.

Parameters:
- EBW, 32, element MSB index; each element is EBW+1 bits, signed.
- ROWS, 1, rows of the vector/matrix.
- COLS, 128, columns of the vector/matrix.
- LEN, ROWS*COLS, total element count; derived, not overridden.
- CW, $clog2(LEN+1), width of the element counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has an element.
- in_ready  out  1  packer can accept an element.
- in_data  in  EBW+1  signed element.
- in_last  in  1  marks the final element of a frame.
- out_valid  out  1  flat_out holds a complete frame.
- out_ready  in  1  consumer accepts the frame.
- flat_out  out  (EBW+1)*LEN  packed vector; element k occupies bits [k*(EBW+1) +: EBW+1], with k = row*COLS + col.
- count  out  CW  elements accepted in the current frame.
- err_len  out  1  frame length mismatch on the last completed frame.
- frame_cnt  out  16  frames handed off since reset; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (async assert, sync release): state=FILL, in_ready=1, out_valid=0, flat_out=0, count=0, err_len=0, frame_cnt=0. Reset mid-frame discards all partial data.
- Accept event = in_valid & in_ready. in_ready equals (state==FILL), combinational from state only. It never depends on in_valid.
- FILL, on accept:
  - Write in_data to slot count; count increments.
  - If in_last=1 or count==LEN-1: go to FULL next cycle and set out_valid=1.
  - Set err_len = (in_last XOR (count==LEN-1)).
- Early in_last (count<LEN-1): the unwritten slots keep 0 (zero-fill), and err_len=1.
- Element LEN-1 arriving without in_last: the frame closes anyway and err_len=1. The next element starts a new frame.
- FULL:
  - in_ready=0, and flat_out is held stable.
  - On out_valid & out_ready: next cycle go to FILL, out_valid=0, count=0, flat_out cleared to 0, frame_cnt+1. err_len is held until the next frame closes.
- Latency:
  - The final accepted element is visible on flat_out, with out_valid=1, one cycle after its accept edge.
  - There is one bubble cycle between a handoff and the next accept, so maximum throughput is LEN+1 cycles per frame.
- out_valid stays high until accepted; it is never withdrawn except by reset.
- in_data is stored as-is, with no width change. Sign is preserved bit-exactly.
- in_valid in FULL is ignored: no accept, no state change.

Optional Feature:
- Macro VEC_PACKER_RELU_EN.
- When defined: each accepted element is clamped as max(0, in_data), i.e. negative values are written as 0. This matches the dense ReLU, so inter-layer loading applies the activation once.
- When undefined: elements are stored unmodified.
- count, err_len and handshake timing are identical in both builds.

Test Plan (EBW=7, ROWS=1, COLS=4):
- Reset, then stream 8'h01,02,03,04 with in_last on the 4th -> out_valid 1 cycle later; flat_out=32'h04030201; err_len=0; count=4; frame_cnt=1 after out_ready.
- Same frame with out_ready held low 5 cycles, in_valid kept high -> in_ready=0; flat_out unchanged; no extra accept; handoff on the first out_ready=1.
- Stream 8'h11,22 with in_last on 2nd -> flat_out=32'h00002211; err_len=1.
- Stream 4 elements, none with in_last -> frame closes after the 4th; err_len=1; a 5th element lands in slot 0 of the next frame.
- Stream 8'hFF,80,7F,00 -> default build flat_out=32'h007F80FF; with VEC_PACKER_RELU_EN flat_out=32'h007F0000.
- Drop rst_n after 2 elements -> out_valid=0, count=0, flat_out=0 immediately; a fresh 4-element frame then packs correctly.
